// File: rtl/mem_reg_pkg.sv
// Shared types and helpers for the mem_reg_bank register file:
// response state encoding, byte-strobe merge and address-width derivation.
package mem_reg_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } rsp_state_t;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MAX_W = 256;
    localparam int unsigned MAX_B = MAX_W / 8;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic logic [MAX_W-1:0] strb_merge(
        input logic [MAX_W-1:0] old_word,
        input logic [MAX_W-1:0] new_word,
        input logic [MAX_B-1:0] strb
    );
        logic [MAX_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MAX_B; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_reg_entry.sv
// One storage word with a written flag: byte-strobed write and synchronous
// flag clear. A simultaneous write re-sets the flag after the clear.
module mem_reg_entry
    import mem_reg_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_we,
    input  logic [NB-1:0]    i_strb,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_word,
    output logic             o_written
);

    logic [WIDTH-1:0] r_word;
    logic             r_written;
    logic [WIDTH-1:0] w_merged;

    assign w_merged = WIDTH'(strb_merge(MAX_W'(r_word), MAX_W'(i_wdata), MAX_B'(i_strb)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word    <= '0;
            r_written <= 1'b0;
        end else begin
            if (i_we) r_word <= w_merged;
            if (i_clear) r_written <= 1'b0;
            if (i_we && (|i_strb)) r_written <= 1'b1;
        end
    end

    assign o_word    = r_word;
    assign o_written = r_written;

endmodule

// File: rtl/mem_reg_bank.sv
// DEPTH x WIDTH register bank with byte-strobed writes, per-word written flags
// and a registered valid/ready read response port with same-cycle write bypass.
module mem_reg_bank
    import mem_reg_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = addr_width(DEPTH),
    localparam int unsigned NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [NB-1:0]    wr_strb,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_gnt,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_err
);

    logic [WIDTH-1:0] w_words [DEPTH];
    logic             w_flags [DEPTH];
    logic [DEPTH-1:0] w_we;

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        assign w_we[k] = wr_en && (wr_addr == AW'(k));

        mem_reg_entry #(.WIDTH(WIDTH)) u_entry (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_clear   (clear),
            .i_we      (w_we[k]),
            .i_strb    (wr_strb),
            .i_wdata   (wr_data),
            .o_word    (w_words[k]),
            .o_written (w_flags[k])
        );
    end

    logic             w_rd_in_range;
    logic [WIDTH-1:0] w_sel_word;
    logic             w_sel_flag;
    logic             w_bypass;
    logic [WIDTH-1:0] w_rsp_data;
    logic             w_rsp_err;

    assign w_rd_in_range = (32'(rd_addr) < DEPTH);

    always_comb begin
        w_sel_word = '0;
        w_sel_flag = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (rd_addr == AW'(k)) begin
                w_sel_word = w_words[k];
                w_sel_flag = w_flags[k];
            end
        end
    end

    assign w_bypass = wr_en && (wr_addr == rd_addr);

    // Response reflects the flag as it will be after this cycle's clear/write.
    always_comb begin
        w_rsp_data = '0;
        w_rsp_err  = 1'b1;
        if (w_rd_in_range) begin
            if (w_bypass) begin
                w_rsp_data = WIDTH'(strb_merge(MAX_W'(w_sel_word), MAX_W'(wr_data), MAX_B'(wr_strb)));
                w_rsp_err  = !((|wr_strb) || (w_sel_flag && !clear));
            end else begin
                w_rsp_data = w_sel_word;
                w_rsp_err  = !(w_sel_flag && !clear);
            end
        end
    end

    rsp_state_t       r_state;
    rsp_state_t       w_next;
    logic             w_capture;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        rd_gnt    = 1'b0;
        case (r_state)
            IDLE: begin
                rd_gnt = 1'b1;
                if (rd_req) begin
                    w_capture = 1'b1;
                    w_next    = HOLD;
                end
            end
            HOLD: begin
                rd_gnt = rd_ready;
                if (rd_ready) begin
                    if (rd_req) w_capture = 1'b1;
                    else        w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_data <= w_rsp_data;
                r_err  <= w_rsp_err;
            end else if (w_next == IDLE) begin
                r_data <= '0;
                r_err  <= 1'b0;
            end
        end
    end

    assign rd_valid = (r_state == HOLD);
    assign rd_data  = r_data;
    assign rd_err   = r_err;

endmodule

// File: tb/tb_mem_reg_bank.sv
// Directed self-checking bench for mem_reg_bank, built with DEPTH=5 so that
// out-of-range addresses are representable on the 3-bit address ports.
module tb_mem_reg_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [1:0]  wr_strb;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_reg_bank #(.WIDTH(16), .DEPTH(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_strb  (wr_strb),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_err   (rd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_strb = '0;
        wr_data = '0; rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b1;
        #12;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", rd_data); end
        n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", rd_err); end
        n_checks++; if (rd_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt: got %b want 1", rd_gnt); end
        reset_n = 1'b1;
    endtask

    task automatic test_read_after_reset();
        rd_req = 1'b1; rd_addr = 3'd2;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_read_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rst_read_data: got %h want 0000", rd_data); end
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL rst_read_err: got %b want 1", rd_err); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_read_release: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL idle_data_zero: got %h want 0000", rd_data); end
    endtask

    task automatic test_strobe_write();
        wr_en = 1'b1; wr_addr = 3'd1; wr_strb = 2'b11; wr_data = 16'hBEEF;
        tick();
        wr_strb = 2'b10; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd1;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_data !== 16'h12EF) begin n_fail++; $display("FAIL strobe_data: got %h want 12ef", rd_data); end
        n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL strobe_err: got %b want 0", rd_err); end
        tick();
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 3'd3; wr_strb = 2'b11; wr_data = 16'hA5A5;
        rd_req = 1'b1; rd_addr = 3'd3;
        tick();
        n_checks++; if (rd_data !== 16'hA5A5) begin n_fail++; $display("FAIL bypass_full_data: got %h want a5a5", rd_data); end
        n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL bypass_full_err: got %b want 0", rd_err); end
        // Partial bypass onto a never-written word: only byte 0 comes from wr_data.
        wr_addr = 3'd0; wr_strb = 2'b01; wr_data = 16'h77CC; rd_addr = 3'd0;
        tick();
        wr_en = 1'b0; rd_req = 1'b0;
        n_checks++; if (rd_data !== 16'h00CC) begin n_fail++; $display("FAIL bypass_part_data: got %h want 00cc", rd_data); end
        n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL bypass_part_err: got %b want 0", rd_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        rd_ready = 1'b1; rd_req = 1'b1; rd_addr = 3'd0;
        tick();
        n_checks++; if (rd_data !== 16'h00CC) begin n_fail++; $display("FAIL b2b_first: got %h want 00cc", rd_data); end
        rd_ready = 1'b0; rd_addr = 3'd1;
        #1;
        n_checks++; if (rd_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_gnt_low: got %b want 0", rd_gnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h00CC || rd_err !== 1'b0 || rd_gnt !== 1'b0)
                begin n_fail++; $display("FAIL b2b_stall%0d: got v=%b d=%h e=%b g=%b want v=1 d=00cc e=0 g=0", i, rd_valid, rd_data, rd_err, rd_gnt); end
        end
        rd_ready = 1'b1;
        #1;
        n_checks++; if (rd_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt_high: got %b want 1", rd_gnt); end
        tick();
        n_checks++; if (rd_data !== 16'h12EF || rd_err !== 1'b0) begin n_fail++; $display("FAIL b2b_addr1: got %h/%b want 12ef/0", rd_data, rd_err); end
        rd_addr = 3'd2;
        tick();
        n_checks++; if (rd_data !== 16'h0000 || rd_err !== 1'b1) begin n_fail++; $display("FAIL b2b_addr2: got %h/%b want 0000/1", rd_data, rd_err); end
        rd_addr = 3'd3;
        tick();
        n_checks++; if (rd_data !== 16'hA5A5 || rd_err !== 1'b0) begin n_fail++; $display("FAIL b2b_addr3: got %h/%b want a5a5/0", rd_data, rd_err); end
        rd_req = 1'b0;
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", rd_valid); end
    endtask

    task automatic test_out_of_range_and_clear();
        wr_en = 1'b1; wr_addr = 3'd6; wr_strb = 2'b11; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd6;
        tick();
        n_checks++; if (rd_data !== 16'h0000 || rd_err !== 1'b1) begin n_fail++; $display("FAIL oor_read: got %h/%b want 0000/1", rd_data, rd_err); end
        rd_addr = 3'd4;
        tick();
        n_checks++; if (rd_data !== 16'h0000 || rd_err !== 1'b1) begin n_fail++; $display("FAIL oor_addr4: got %h/%b want 0000/1", rd_data, rd_err); end
        rd_addr = 3'd1;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_data !== 16'h12EF || rd_err !== 1'b0) begin n_fail++; $display("FAIL oor_addr1: got %h/%b want 12ef/0", rd_data, rd_err); end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd1;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_data !== 16'h12EF || rd_err !== 1'b1) begin n_fail++; $display("FAIL clear_retain: got %h/%b want 12ef/1", rd_data, rd_err); end
        tick();
    endtask

    task automatic test_clear_same_cycle();
        clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_strb = 2'b11; wr_data = 16'h5A5A;
        rd_req = 1'b1; rd_addr = 3'd2;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        n_checks++; if (rd_data !== 16'h5A5A || rd_err !== 1'b0) begin n_fail++; $display("FAIL clr_wr_bypass: got %h/%b want 5a5a/0", rd_data, rd_err); end
        tick();
        n_checks++; if (rd_data !== 16'h5A5A || rd_err !== 1'b0) begin n_fail++; $display("FAIL clr_wr_stored: got %h/%b want 5a5a/0", rd_data, rd_err); end
        clear = 1'b1;
        tick();
        clear = 1'b0; rd_req = 1'b0;
        n_checks++; if (rd_data !== 16'h5A5A || rd_err !== 1'b1) begin n_fail++; $display("FAIL clr_rd_same: got %h/%b want 5a5a/1", rd_data, rd_err); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        rd_ready = 1'b0; rd_req = 1'b1; rd_addr = 3'd2;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL hold_entered: got %b want 1", rd_valid); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin n_fail++; $display("FAIL async_reset: got v=%b d=%h want v=0 d=0000", rd_valid, rd_data); end
        #2 reset_n = 1'b1;
        rd_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_req = 1'b1; rd_addr = 3'(a);
            tick();
            n_checks++; if (rd_data !== 16'h0000 || rd_err !== 1'b1) begin n_fail++; $display("FAIL post_reset_addr%0d: got %h/%b want 0000/1", a, rd_data, rd_err); end
        end
        rd_req = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_after_reset();
        test_strobe_write();
        test_bypass();
        test_back_to_back();
        test_out_of_range_and_clear();
        test_clear_same_cycle();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
